// File: rtl/systolic_seq_ctrl_if.sv
// Operand and result streams between the systolic sequencer and its host.
// The slave modport is the sequencer side; the master modport is the host side.
interface systolic_seq_ctrl_if;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready
    );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a systolic array: clear, load 64 B and 8 A words, shift, drain 8 partial sums.
// Outputs are combinational from registered state; input stalls and out_ready=0 simply hold the counters.
module systolic_seq_ctrl #(
    parameter int SHIFT_CYCLES = 16
) (
    input  logic                Clock,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    systolic_seq_ctrl_if.slave  io,
    output logic                busy,
    output logic                done,
    output logic                external_we,
    output logic                sel_a_or_b,
    output logic [5:0]          b_sel,
    output logic [2:0]          a_sel,
    output logic [15:0]         external_wdata,
    output logic                data_clear,
    output logic                en_shift_right,
    output logic                en_shift_bottom,
    output logic [2:0]          ps_sel,
    input  logic [15:0]         ps_bottom_out
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD_B,
        LOAD_A,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    localparam logic [7:0] SHIFT_LAST = 8'(SHIFT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [5:0]  word_cnt, word_cnt_nxt;
    logic [7:0]  shift_cnt, shift_cnt_nxt;

    logic        in_rdy;
    logic        in_acc;
    logic        out_vld;
    logic [15:0] out_dat;

    always_ff @(posedge Clock or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            word_cnt  <= 6'd0;
            shift_cnt <= 8'd0;
        end else begin
            state     <= state_nxt;
            word_cnt  <= word_cnt_nxt;
            shift_cnt <= shift_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        word_cnt_nxt    = word_cnt;
        shift_cnt_nxt   = shift_cnt;
        in_rdy          = 1'b0;
        in_acc          = 1'b0;
        out_vld         = 1'b0;
        out_dat         = 16'd0;
        done            = 1'b0;
        external_we     = 1'b0;
        sel_a_or_b      = 1'b0;
        b_sel           = 6'd0;
        a_sel           = 3'd0;
        external_wdata  = 16'd0;
        data_clear      = 1'b0;
        en_shift_right  = 1'b0;
        en_shift_bottom = 1'b0;
        ps_sel          = 3'd0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CLEAR;
                end
            end

            CLEAR: begin
                data_clear   = 1'b1;
                word_cnt_nxt = 6'd0;
                state_nxt    = LOAD_B;
            end

            LOAD_B: begin
                in_rdy = 1'b1;
                in_acc = io.in_valid;
                b_sel  = word_cnt;
                if (in_acc) begin
                    external_we    = 1'b1;
                    external_wdata = io.in_data;
                    if (word_cnt == 6'd63) begin
                        word_cnt_nxt = 6'd0;
                        state_nxt    = LOAD_A;
                    end else begin
                        word_cnt_nxt = word_cnt + 6'd1;
                    end
                end
            end

            LOAD_A: begin
                in_rdy     = 1'b1;
                in_acc     = io.in_valid;
                sel_a_or_b = 1'b1;
                a_sel      = word_cnt[2:0];
                if (in_acc) begin
                    external_we    = 1'b1;
                    external_wdata = io.in_data;
                    if (word_cnt[2:0] == 3'd7) begin
                        word_cnt_nxt  = 6'd0;
                        shift_cnt_nxt = 8'd0;
                        state_nxt     = SHIFT;
                    end else begin
                        word_cnt_nxt = word_cnt + 6'd1;
                    end
                end
            end

            SHIFT: begin
                en_shift_right  = 1'b1;
                en_shift_bottom = 1'b1;
                if (shift_cnt == SHIFT_LAST) begin
                    shift_cnt_nxt = 8'd0;
                    word_cnt_nxt  = 6'd0;
                    state_nxt     = DRAIN;
                end else begin
                    shift_cnt_nxt = shift_cnt + 8'd1;
                end
            end

            // ps_sel only moves on a completed transfer, so out_data holds under backpressure
            DRAIN: begin
                out_vld = 1'b1;
                ps_sel  = word_cnt[2:0];
                out_dat = ps_bottom_out;
                if (io.out_ready) begin
                    if (word_cnt[2:0] == 3'd7) begin
                        word_cnt_nxt = 6'd0;
                        state_nxt    = DONE;
                    end else begin
                        word_cnt_nxt = word_cnt + 6'd1;
                    end
                end
            end

            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Cancel wins over everything, including a start seen in IDLE
        if (abort) begin
            state_nxt     = IDLE;
            word_cnt_nxt  = 6'd0;
            shift_cnt_nxt = 8'd0;
        end
    end

    assign busy         = (state != IDLE);
    assign io.in_ready  = in_rdy;
    assign io.out_valid = out_vld;
    assign io.out_data  = out_dat;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl: full runs with/without gaps, drain backpressure, abort, reset.
module tb_systolic_seq_ctrl;

    logic        Clock = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        external_we;
    logic        sel_a_or_b;
    logic [5:0]  b_sel;
    logic [2:0]  a_sel;
    logic [15:0] external_wdata;
    logic        data_clear;
    logic        en_shift_right;
    logic        en_shift_bottom;
    logic [2:0]  ps_sel;
    logic [15:0] ps_bottom_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    systolic_seq_ctrl_if io ();

    systolic_seq_ctrl #(.SHIFT_CYCLES(16)) dut (
        .Clock           (Clock),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .io              (io),
        .busy            (busy),
        .done            (done),
        .external_we     (external_we),
        .sel_a_or_b      (sel_a_or_b),
        .b_sel           (b_sel),
        .a_sel           (a_sel),
        .external_wdata  (external_wdata),
        .data_clear      (data_clear),
        .en_shift_right  (en_shift_right),
        .en_shift_bottom (en_shift_bottom),
        .ps_sel          (ps_sel),
        .ps_bottom_out   (ps_bottom_out)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({busy, done, external_we, sel_a_or_b, b_sel, a_sel, external_wdata,
                    data_clear, en_shift_right, en_shift_bottom, ps_sel,
                    io.in_ready, io.out_valid, io.out_data});
    endfunction

    task automatic step();
        @(posedge Clock);
        #1;
        cyc++;
    endtask

    // One full run from start; abort_at >= 0 cancels in that zero-based shift cycle.
    task automatic do_run(input bit gaps, input bit stall3, input int abort_at);
        int          stalls;
        int          gap_n;
        logic [15:0] val;
        stalls = 0;
        cyc    = 0;
        start  = 1'b1;
        step();
        start  = 1'b0;
        #1;
        check("clear", 64'({data_clear, busy, io.in_ready, external_we}), 64'(4'b1100));
        step();

        for (int i = 0; i < 64; i++) begin
            gap_n = 0;
            while (gaps && gap_n < 3 && $urandom_range(0, 1) == 1) begin
                io.in_valid = 1'b0;
                #1;
                check("stall_b", 64'({io.in_ready, external_we, b_sel}), 64'({1'b1, 1'b0, 6'(i)}));
                stalls++;
                gap_n++;
                step();
            end
            io.in_valid = 1'b1;
            io.in_data  = 16'(i + 1);
            if (i == 0) start = 1'b1;
            #1;
            check("wr_b", 64'({external_we, sel_a_or_b, b_sel, external_wdata}),
                  64'({1'b1, 1'b0, 6'(i), 16'(i + 1)}));
            start = 1'b0;
            step();
        end

        for (int j = 0; j < 8; j++) begin
            gap_n = 0;
            while (gaps && gap_n < 3 && $urandom_range(0, 1) == 1) begin
                io.in_valid = 1'b0;
                #1;
                check("stall_a", 64'({io.in_ready, external_we, a_sel}), 64'({1'b1, 1'b0, 3'(j)}));
                stalls++;
                gap_n++;
                step();
            end
            io.in_valid = 1'b1;
            io.in_data  = 16'h0100 + 16'(j);
            #1;
            check("wr_a", 64'({external_we, sel_a_or_b, a_sel, external_wdata}),
                  64'({1'b1, 1'b1, 3'(j), 16'h0100 + 16'(j)}));
            step();
        end
        io.in_valid = 1'b0;

        for (int k = 0; k < 16; k++) begin
            #1;
            check("shift", 64'({en_shift_right, en_shift_bottom, io.in_ready, external_we}), 64'(4'b1100));
            if (k == abort_at) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                #1;
                check("abort_idle", 64'({busy, en_shift_right, en_shift_bottom, done}), 64'd0);
                step();
                check("abort_no_done", 64'({busy, done}), 64'd0);
                return;
            end
            step();
        end

        io.out_ready = 1'b1;
        for (int p = 0; p < 8; p++) begin
            val           = 16'hC000 + 16'(p) * 16'h0111;
            ps_bottom_out = val;
            if (stall3 && p == 3) begin
                io.out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    #1;
                    check("hold", 64'({io.out_valid, ps_sel, io.out_data}), 64'({1'b1, 3'd3, val}));
                    stalls++;
                    step();
                end
                io.out_ready = 1'b1;
            end
            #1;
            check("drain", 64'({io.out_valid, ps_sel, io.out_data, busy}), 64'({1'b1, 3'(p), val, 1'b1}));
            step();
        end
        io.out_ready = 1'b0;

        #1;
        check("done", 64'({done, busy, io.out_valid, en_shift_right}), 64'(4'b1100));
        check("latency", 64'(cyc), 64'(98 + stalls));
        step();
        check("idle_after", 64'({done, busy}), 64'd0);
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        io.in_valid   = 1'b1;
        io.in_data    = 16'hFFFF;
        io.out_ready  = 1'b1;
        ps_bottom_out = 16'hFFFF;
        #12;
        check("reset", all_outs(), 64'd0);
        io.in_valid  = 1'b0;
        io.out_ready = 1'b0;
        @(negedge Clock);
        rst = 1'b0;

        do_run(1'b0, 1'b0, -1);
        do_run(1'b1, 1'b0, -1);
        do_run(1'b0, 1'b1, -1);
        do_run(1'b0, 1'b0, 6);
        do_run(1'b0, 1'b0, -1);

        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        #1;
        check("start_abort", 64'({busy, data_clear}), 64'd0);
        step();
        check("start_abort_hold", 64'({busy, data_clear}), 64'd0);

        start = 1'b1;
        step();
        start = 1'b0;
        step();
        for (int i = 0; i < 30; i++) begin
            io.in_valid = 1'b1;
            io.in_data  = 16'(i + 1);
            step();
        end
        io.in_valid = 1'b1;
        io.in_data  = 16'd31;
        #1;
        check("pre_rst", 64'({external_we, b_sel, busy}), 64'({1'b1, 6'd30, 1'b1}));
        rst = 1'b1;
        #1;
        check("rst_async", all_outs(), 64'd0);
        io.in_valid = 1'b0;
        @(negedge Clock);
        rst = 1'b0;
        do_run(1'b0, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/systolic_seq_ctrl.md
SYSTOLIC_SEQ_CTRL -- requirements
Module: systolic_seq_ctrl

Interface
REQ-001 SHALL have parameter SHIFT_CYCLES, default 16, giving the number of shift-enable cycles per run (legal range 1..255).
REQ-002 SHALL have port Clock, in, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, in, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, in, 1: begins a run when sampled in IDLE.
REQ-005 SHALL have port abort, in, 1: synchronous cancel of the current run.
REQ-006 SHALL have port in_valid, in, 1: operand word valid.
REQ-007 SHALL have port in_data, in, 16: operand word.
REQ-008 SHALL have port in_ready, out, 1: operand word accepted when high together with in_valid.
REQ-009 SHALL have port out_valid, out, 1: result word valid.
REQ-010 SHALL have port out_data, out, 16: result word.
REQ-011 SHALL have port out_ready, in, 1: result consumer ready.
REQ-012 SHALL have port busy, out, 1: high in every state except IDLE.
REQ-013 SHALL have port done, out, 1: one-cycle completion pulse.
REQ-014 SHALL have port external_we, out, 1: array register write strobe.
REQ-015 SHALL have port sel_a_or_b, out, 1: 0 selects B write, 1 selects A write.
REQ-016 SHALL have port b_sel, out, 6: B register index.
REQ-017 SHALL have port a_sel, out, 3: A register index.
REQ-018 SHALL have port external_wdata, out, 16: array write data.
REQ-019 SHALL have port data_clear, out, 1: array accumulator clear.
REQ-020 SHALL have port en_shift_right, out, 1: array horizontal shift enable.
REQ-021 SHALL have port en_shift_bottom, out, 1: array vertical shift enable.
REQ-022 SHALL have port ps_sel, out, 3: partial-sum column select.
REQ-023 SHALL have port ps_bottom_out, in, 16: selected partial sum from the array.

Function
REQ-024 SHALL implement FSM states IDLE, CLEAR, LOAD_B, LOAD_A, SHIFT, DRAIN, DONE with a 6-bit word counter and an 8-bit shift counter.
REQ-025 SHALL transition IDLE->CLEAR on start; start SHALL be ignored in all other states.
REQ-026 SHALL assert data_clear for exactly the one CLEAR cycle, then go to LOAD_B with the word counter at 0.
REQ-027 In LOAD_B, SHALL drive in_ready=1; on each in_valid&in_ready cycle, SHALL drive external_we=1, sel_a_or_b=0, b_sel=counter, external_wdata=in_data in that same cycle (combinational from registered state), and increment the counter.
REQ-028 SHALL go LOAD_B->LOAD_A with the counter cleared on the 64th accepted word (counter 63).
REQ-029 SHALL apply REQ-027 rules in LOAD_A with sel_a_or_b=1, a_sel=counter[2:0], and go to SHIFT on the 8th accepted word.
REQ-030 SHALL hold the counter unchanged and drive external_we=0 on any cycle where in_valid=0 (input stall).
REQ-031 SHALL drive in_ready=0 outside LOAD_B and LOAD_A.
REQ-032 SHALL assert en_shift_right and en_shift_bottom together for exactly SHIFT_CYCLES consecutive cycles in SHIFT, then go to DRAIN with the counter at 0.
REQ-033 In DRAIN, SHALL drive ps_sel=counter[2:0], out_valid=1, out_data=ps_bottom_out; on out_valid&out_ready, SHALL increment the counter; after the 8th transfer SHALL go to DONE.
REQ-034 SHALL keep ps_sel, and therefore out_data, stable while out_valid=1 and out_ready=0.
REQ-035 SHALL assert done for the single DONE cycle, then return to IDLE.
REQ-036 abort SHALL force IDLE on the next edge from any state; outputs SHALL deassert that cycle; already-written array data is not undone; abort SHALL win over a simultaneous start.
REQ-037 Outside the states named in REQ-026..REQ-035, each strobe, valid, and index output SHALL be 0.

Reset
REQ-038 rst high SHALL immediately force IDLE with counters at 0, and every output at 0, including mid-run.
REQ-039 After rst deasserts, the block SHALL accept start on the first following edge.

Verification
REQ-040 Reset -> start, feed 64 B words 0x0001..0x0040 then 8 A words 0x0100..0x0107 with no stalls -> 1 data_clear cycle, 72 external_we pulses with b_sel 0..63 then a_sel 0..7 and matching wdata, 16 shift cycles, 8 out transfers with ps_sel 0..7, one done pulse; total 1+72+16+8+1 cycles after start.
REQ-041 Random in_valid gaps (50%) -> identical write sequence; no write while in_valid=0.
REQ-042 Hold out_ready=0 for 5 cycles at ps_sel=3 -> out_valid and out_data steady; resumes with ps_sel=4 after transfer.
REQ-043 Assert abort during SHIFT cycle 7 -> shifts stop the next cycle, busy=0, no done; a new start runs normally.
REQ-044 Assert rst during LOAD_B at word 30 -> all outputs 0 asynchronously; subsequent start restarts at b_sel=0.
REQ-045 Pulse start while busy, and start with abort in IDLE -> both ignored, no state change.
